dmem_responder: RTL and testbench

Data-memory responder for the pipelined MIPS core. It serves the memory-stage load/store port: a byte address, store data, a 4-bit byte-lane write enable and a request strobe. Each access completes after a programmable number of wait states. While an access is in flight it raises a stall to the hazard unit. It holds a word-organised big-endian array and returns whole words; load lane extraction and sign extension stay in the writeback stage.

---
 rtl/dmem_responder.sv | 165 ++++++++++++++++
 tb/tb_dmem_responder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the memory stage: a big-endian, word-organised
// array that completes each load or store after WAIT_CYCLES wait states and
// holds the pipeline in a stall while the access is in flight.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [3:0]  we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        stall,
    output logic        err
);

    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0] CNT_INIT  = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [3:0]            cnt;
    logic [3:0]            cnt_next;
    logic                  capture;
    logic                  do_access;
    logic                  commit;

    logic [ADDR_WIDTH-1:0] lat_index;
    logic [3:0]            lat_we;
    logic [31:0]           lat_wdata;

    logic [ADDR_WIDTH-1:0] acc_index;
    logic [3:0]            acc_we;
    logic [31:0]           acc_wdata;
    logic                  acc_legal;

    logic [31:0]           mem [DEPTH];

    logic                  unused_addr_bits;

    // Lane choice within a word belongs to the core, and the high bits wrap.
    assign unused_addr_bits = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};

    // Only whole words, aligned halfwords and single bytes are legal enables.
    function automatic logic legal_we(input logic [3:0] w);
        case (w)
            4'b0000, 4'b1111, 4'b1100, 4'b0011,
            4'b1000, 4'b0100, 4'b0010, 4'b0001: legal_we = 1'b1;
            default:                            legal_we = 1'b0;
        endcase
    endfunction

    // Access fields: with zero wait states the access happens at the capture edge,
    // so the live inputs are used; otherwise the latched copy is used.
    always_comb begin
        acc_index = lat_index;
        acc_we    = lat_we;
        acc_wdata = lat_wdata;
        if (state == IDLE) begin
            acc_index = addr[ADDR_WIDTH+1:2];
            acc_we    = we;
            acc_wdata = wdata;
        end
    end

    assign acc_legal = legal_we(acc_we);
    assign commit    = do_access & rst;
    assign stall     = rst & req & (state != RESP);

    // Next-state logic: IDLE samples a request, WAIT counts down, RESP lasts one cycle.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        do_access  = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    capture = 1'b1;
                    if (ZERO_WAIT) begin
                        do_access  = 1'b1;
                        state_next = RESP;
                    end else begin
                        cnt_next   = CNT_INIT;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_next = cnt - 4'd1;
                end else begin
                    do_access  = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and wait counter registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Capture the request so later input changes cannot disturb it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_index <= '0;
            lat_we    <= 4'b0000;
            lat_wdata <= 32'd0;
        end else if (capture) begin
            lat_index <= addr[ADDR_WIDTH+1:2];
            lat_we    <= we;
            lat_wdata <= wdata;
        end
    end

    // Array write: only enabled lanes change; contents survive reset.
    always_ff @(posedge clk) begin
        if (commit && acc_legal) begin
            if (acc_we[3]) mem[acc_index][31:24] <= acc_wdata[31:24];
            if (acc_we[2]) mem[acc_index][23:16] <= acc_wdata[23:16];
            if (acc_we[1]) mem[acc_index][15:8]  <= acc_wdata[15:8];
            if (acc_we[0]) mem[acc_index][7:0]   <= acc_wdata[7:0];
        end
    end

    // Registered response: ready and err pulse for the RESP cycle, rdata updates on legal reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= 32'd0;
            ready <= 1'b0;
            err   <= 1'b0;
        end else begin
            ready <= commit;
            err   <= commit & ~acc_legal;
            if (commit && acc_legal && (acc_we == 4'b0000)) begin
                rdata <= mem[acc_index];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: three instances (2, 0 and 4 wait states)
// driven with directed and random accesses against a word-array model.
module tb_dmem_responder;

    localparam int N     = 3;
    localparam int DEPTH = 1024;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        req_v;
    logic [N-1:0][3:0]   we_v;
    logic [N-1:0][31:0]  addr_v;
    logic [N-1:0][31:0]  wdata_v;
    logic [N-1:0][31:0]  rdata_v;
    logic [N-1:0]        ready_v;
    logic [N-1:0]        stall_v;
    logic [N-1:0]        err_v;

    int                  total = 0;
    int                  bad   = 0;

    logic [31:0]         model_mem   [N][DEPTH];
    logic [31:0]         model_rdata [N];

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        dmem_responder #(
            .ADDR_WIDTH (10),
            .WAIT_CYCLES((g == 0) ? 2 : ((g == 1) ? 0 : 4))
        ) u_dut (
            .clk  (clk),
            .rst  (rst),
            .req  (req_v[g]),
            .we   (we_v[g]),
            .addr (addr_v[g]),
            .wdata(wdata_v[g]),
            .rdata(rdata_v[g]),
            .ready(ready_v[g]),
            .stall(stall_v[g]),
            .err  (err_v[g])
        );
    end

    function automatic int waitOf(input int sel);
        return (sel == 0) ? 2 : ((sel == 1) ? 0 : 4);
    endfunction

    function automatic bit isLegal(input logic [3:0] w);
        logic [3:0] legal_list [$] = '{4'b0000, 4'b1111, 4'b1100, 4'b0011,
                                       4'b1000, 4'b0100, 4'b0010, 4'b0001};
        foreach (legal_list[i]) begin
            if (legal_list[i] == w) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One complete access on instance sel, starting just after a falling edge.
    task automatic applyStimulus(input int sel, input logic [3:0] w, input logic [31:0] a,
                                 input logic [31:0] d, input bit flush, input string tag);
        int          wc;
        int          idx;
        logic [31:0] word;
        logic [31:0] exp_rdata;
        bit          legal;

        wc        = waitOf(sel);
        idx       = int'((a >> 2) % DEPTH);
        legal     = isLegal(w);
        exp_rdata = model_rdata[sel];
        if (legal) begin
            if (w == 4'b0000) begin
                exp_rdata = model_mem[sel][idx];
            end else begin
                word = model_mem[sel][idx];
                for (int lane = 0; lane < 4; lane++) begin
                    if (w[3-lane]) word[31-8*lane -: 8] = d[31-8*lane -: 8];
                end
                model_mem[sel][idx] = word;
            end
        end
        model_rdata[sel] = exp_rdata;

        req_v[sel]   = 1'b1;
        we_v[sel]    = w;
        addr_v[sel]  = a;
        wdata_v[sel] = d;
        for (int k = 0; k <= wc + 1; k++) begin
            if (k > 0) begin
                @(negedge clk);
                if (flush && k == 1) req_v[sel] = 1'b0;
                if (k <= wc) begin
                    we_v[sel]    = 4'($urandom);
                    addr_v[sel]  = $urandom;
                    wdata_v[sel] = $urandom;
                end
            end
            #1;
            checkOutput({tag, " ready"}, 32'(ready_v[sel]), 32'(k == wc + 1));
            checkOutput({tag, " stall"}, 32'(stall_v[sel]),
                        32'((k <= wc) && !(flush && k >= 1)));
            if (k == wc + 1) begin
                checkOutput({tag, " err"}, 32'(err_v[sel]), 32'(!legal));
                checkOutput({tag, " rdata"}, rdata_v[sel], exp_rdata);
            end
        end
        req_v[sel]   = 1'b0;
        we_v[sel]    = 4'b0000;
        @(negedge clk);
        #1;
        checkOutput({tag, " idle ready"}, 32'(ready_v[sel]), 32'd0);
        checkOutput({tag, " idle stall"}, 32'(stall_v[sel]), 32'd0);
    endtask

    initial begin
        int          pool [6] = '{0, 1, 5, 17, 511, 1023};
        int          idx;
        logic [3:0]  w;
        logic [31:0] a;

        rst     = 1'b0;
        req_v   = '0;
        we_v    = '0;
        addr_v  = '0;
        wdata_v = '0;
        for (int s = 0; s < N; s++) model_rdata[s] = 32'd0;

        // Reset held for three cycles, then quiet period.
        repeat (3) @(negedge clk);
        #1;
        for (int s = 0; s < N; s++) begin
            checkOutput("reset rdata", rdata_v[s], 32'd0);
            checkOutput("reset ready", 32'(ready_v[s]), 32'd0);
            checkOutput("reset err", 32'(err_v[s]), 32'd0);
            checkOutput("reset stall", 32'(stall_v[s]), 32'd0);
        end
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            for (int s = 0; s < N; s++) begin
                checkOutput("quiet ready", 32'(ready_v[s]), 32'd0);
                checkOutput("quiet stall", 32'(stall_v[s]), 32'd0);
            end
        end

        // Word write/read and lane writes with two wait states.
        applyStimulus(0, 4'b1111, 32'h10, 32'hDEADBEEF, 1'b0, "word wr");
        applyStimulus(0, 4'b0000, 32'h10, 32'h0, 1'b0, "word rd");
        checkOutput("word rd value", rdata_v[0], 32'hDEADBEEF);
        applyStimulus(0, 4'b1111, 32'h20, 32'h11223344, 1'b0, "lane pre");
        applyStimulus(0, 4'b0100, 32'h20, 32'hAAAAAAAA, 1'b0, "byte wr");
        applyStimulus(0, 4'b0000, 32'h20, 32'h0, 1'b0, "byte rd");
        checkOutput("byte rd value", rdata_v[0], 32'h11AA3344);
        applyStimulus(0, 4'b0011, 32'h20, 32'hBBCCBBCC, 1'b0, "half wr");
        applyStimulus(0, 4'b0000, 32'h20, 32'h0, 1'b0, "half rd");
        checkOutput("half rd value", rdata_v[0], 32'h11AABBCC);
        applyStimulus(0, 4'b1010, 32'h20, 32'hFFFFFFFF, 1'b0, "illegal wr");
        applyStimulus(0, 4'b0000, 32'h20, 32'h0, 1'b0, "illegal rd");
        checkOutput("illegal rd value", rdata_v[0], 32'h11AABBCC);

        // Address wrap with zero wait states.
        applyStimulus(1, 4'b1111, 32'h1000, 32'h00000055, 1'b0, "wrap wr");
        applyStimulus(1, 4'b0000, 32'h0000, 32'h0, 1'b0, "wrap rd");
        checkOutput("wrap rd value", rdata_v[1], 32'h00000055);

        // Reset in the middle of a four-wait-state write.
        applyStimulus(2, 4'b1111, 32'h40, 32'hCAFEF00D, 1'b0, "rst pre wr");
        applyStimulus(2, 4'b0000, 32'h40, 32'h0, 1'b0, "rst pre rd");
        req_v[2]   = 1'b1;
        we_v[2]    = 4'b1111;
        addr_v[2]  = 32'h40;
        wdata_v[2] = 32'h12345678;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midrst rdata", rdata_v[2], 32'd0);
        checkOutput("midrst ready", 32'(ready_v[2]), 32'd0);
        checkOutput("midrst err", 32'(err_v[2]), 32'd0);
        checkOutput("midrst stall", 32'(stall_v[2]), 32'd0);
        req_v[2] = 1'b0;
        we_v[2]  = 4'b0000;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int s = 0; s < N; s++) model_rdata[s] = 32'd0;
        @(negedge clk);
        applyStimulus(2, 4'b0000, 32'h40, 32'h0, 1'b0, "midrst rd");
        checkOutput("midrst rd value", rdata_v[2], 32'hCAFEF00D);

        // Randomised traffic on a pool of words per instance.
        for (int s = 0; s < N; s++) begin
            foreach (pool[p]) begin
                a = ($urandom & 32'hFFFF_F003) | (32'(pool[p]) << 2);
                applyStimulus(s, 4'b1111, a, $urandom, 1'b0, "rand init");
            end
            for (int n = 0; n < 40; n++) begin
                idx = pool[$urandom_range(0, 5)];
                a   = ($urandom & 32'hFFFF_F003) | (32'(idx) << 2);
                w   = ($urandom_range(0, 9) < 4) ? 4'b0000 : 4'($urandom);
                applyStimulus(s, w, a, $urandom, ($urandom_range(0, 4) == 0), "rand");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
